// File: rtl/output_bram_drainer.sv
// output_bram_drainer
//   Reader end of the PE output BRAM. After accumulation finishes, reads
//   num_pixels accumulator words over BRAM port B in address order,
//   requantizes each one (round half up, arithmetic shift, optional ReLU,
//   saturate to OUT_WIDTH) and streams the result on an AXI-Stream master.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               1-cycle pulse, accepted only when idle
//   num_pixels          words to drain (0..2^ADDR_WIDTH), sampled on start
//   shift_amt, relu_en  requantize controls, sampled on start
//   busy                high from accepted start through the done cycle
//   done                1-cycle pulse after the final beat is accepted
//   enb_output_BRAM     port B read enable
//   addrb_output_BRAM   port B read address
//   BRAM_doutb          port B read data, valid one cycle after enable
//   m_axis_*            requantized pixel stream, tlast on the final pixel
module output_bram_drainer #(
  parameter int unsigned RESULT_WIDTH = 48,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned SHIFT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     num_pixels,
  input  logic [SHIFT_WIDTH-1:0]  shift_amt,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic                    enb_output_BRAM,
  output logic [ADDR_WIDTH-1:0]   addrb_output_BRAM,
  input  logic [RESULT_WIDTH-1:0] BRAM_doutb,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int unsigned IW = RESULT_WIDTH + 1;

  localparam logic signed [IW-1:0] SAT_MAX = {{(IW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {{(IW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]    rem_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;
  logic                   inflight_q;
  logic                   inflight_last_q;

  logic [OUT_WIDTH-1:0]   fifo_data_q [2];
  logic                   fifo_last_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             occ_q;

  logic                   start_ok;
  logic                   issue;
  logic                   last_issue;
  logic                   push;
  logic                   pop;
  logic [2:0]             level_after_pop;

  logic signed [IW-1:0]   x_ext;
  logic [IW-1:0]          rnd;
  logic signed [IW-1:0]   r_shift;
  logic [OUT_WIDTH-1:0]   q_data;

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = inflight_q;

  // Occupancy counts the head that leaves this cycle as free, so a new read
  // can issue alongside a pop; this keeps one beat per cycle under steady
  // tready while buffered + in-flight never exceeds two after any edge.
  assign level_after_pop = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (num_pixels == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue = (level_after_pop < 3'd2);
        if (issue && (rem_q == (ADDR_WIDTH+1)'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish as soon as the final beat is handed off this cycle.
        if (!inflight_q && (level_after_pop == 3'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign last_issue = issue && (rem_q == (ADDR_WIDTH+1)'(1));

  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign enb_output_BRAM   = issue;
  assign addrb_output_BRAM = addr_q;
  assign m_axis_tvalid     = (occ_q != 2'd0);
  assign m_axis_tdata      = fifo_data_q[rd_ptr_q];
  assign m_axis_tlast      = m_axis_tvalid & fifo_last_q[rd_ptr_q];

  // Requantize the word arriving from the BRAM; shift 0 gives a zero
  // rounding term so one formula covers every shift value.
  always_comb begin
    x_ext = {BRAM_doutb[RESULT_WIDTH-1], BRAM_doutb};
    rnd   = '0;
    if (shift_q != '0) begin
      rnd = IW'(1) << (shift_q - SHIFT_WIDTH'(1));
    end
    r_shift = (x_ext + $signed(rnd)) >>> shift_q;
    if (relu_q && r_shift[IW-1]) begin
      q_data = '0;
    end else if (r_shift > SAT_MAX) begin
      q_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (r_shift < SAT_MIN) begin
      q_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      q_data = r_shift[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q           <= '0;
      addr_q          <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= '0;
    end else begin
      if (start_ok) begin
        rem_q   <= num_pixels;
        addr_q  <= '0;
        shift_q <= shift_amt;
        relu_q  <= relu_en;
      end else if (issue) begin
        rem_q <= rem_q - (ADDR_WIDTH+1)'(1);
        // Hold on the final address so a full-depth drain never wraps.
        if (!last_issue) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      inflight_q      <= issue;
      inflight_last_q <= last_issue;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= q_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_output_bram_drainer.sv
module tb_output_bram_drainer;

  localparam int RW    = 48;
  localparam int OW    = 16;
  localparam int AW    = 14;
  localparam int SW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_pixels = '0;
  logic [SW-1:0] shift_amt = '0;
  logic          relu_en = 1'b0;
  logic          busy, done, enb;
  logic [AW-1:0] addrb;
  logic [RW-1:0] doutb = '0;
  logic [OW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b0;

  always #5 clk = ~clk;

  output_bram_drainer #(
    .RESULT_WIDTH(RW),
    .OUT_WIDTH   (OW),
    .ADDR_WIDTH  (AW),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_pixels       (num_pixels),
    .shift_amt        (shift_amt),
    .relu_en          (relu_en),
    .busy             (busy),
    .done             (done),
    .enb_output_BRAM  (enb),
    .addrb_output_BRAM(addrb),
    .BRAM_doutb       (doutb),
    .m_axis_tdata     (tdata),
    .m_axis_tvalid    (tvalid),
    .m_axis_tready    (tready),
    .m_axis_tlast     (tlast)
  );

  // BRAM port B model: registered read.
  logic [RW-1:0] mem [DEPTH];
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int vectors = 0;
  int miscompares = 0;
  int cur_n = 0;
  logic signed [OW-1:0] got [$];

  task automatic chk(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference requantizer, in plain 64-bit integer arithmetic.
  function automatic logic signed [OW-1:0] ref_q(input logic [RW-1:0] w, input int s, input bit rl);
    longint x, r;
    x = longint'($signed(w));
    if (s == 0) r = x;
    else r = (x + (longint'(1) << (s - 1))) >>> s;
    if (rl && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return OW'(r);
  endfunction

  // Bus monitor: read addresses in order, bounded count, bounded backlog.
  int mon_issued = 0;
  int mon_hs = 0;
  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      if (enb === 1'b1) chk("enb_while_idle", 1, 0);
      mon_issued = 0;
      mon_hs = 0;
    end else begin
      if (enb) begin
        chk("addrb_order", addrb, mon_issued);
        mon_issued++;
        if (mon_issued > cur_n) chk("reads_beyond_n", mon_issued, cur_n);
      end
      if (tvalid && tready) mon_hs++;
      if (mon_issued - mon_hs > 2) chk("backlog_le_2", mon_issued - mon_hs, 2);
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Runs one drain. mode: 0 tready=1, 1 pattern 1,0,0,1, 2 random.
  // poke pulses start mid-drain; abort_at returns after that many beats.
  task automatic drain(input int n, input int sh, input bit rl, input int mode,
                       input bit poke, input int abort_at);
    int beats = 0;
    int last_hs = -10;
    bit stalled = 0;
    bit first_seen = 0;
    bit finished = 0;
    logic [OW-1:0] held_d = '0;
    logic held_l = 1'b0;
    logic signed [OW-1:0] expq [$];
    for (int i = 0; i < n; i++) expq.push_back(ref_q(mem[i], sh, rl));
    got.delete();
    cur_n = n;
    @(posedge clk); #1;
    start = 1'b1;
    num_pixels = (AW+1)'(n);
    shift_amt = SW'(sh);
    relu_en = rl;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < n * 6 + 40 && !finished; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (mode == 0) tready = 1'b1;
      else if (mode == 1) tready = pat[cyc % 4];
      else tready = 1'($urandom_range(0, 1));
      if (poke && cyc == 3) begin
        start = 1'b1;
        num_pixels = (AW+1)'(1);
      end else begin
        start = 1'b0;
        num_pixels = (AW+1)'(n);
      end
      @(negedge clk);
      if (stalled) begin
        chk("tvalid_held", tvalid, 1);
        chk("tdata_held", tdata, held_d);
        chk("tlast_held", tlast, held_l);
      end
      if (done) begin
        chk("beats_at_done", beats, n);
        chk("done_cycle", cyc, (n == 0) ? 0 : last_hs + 1);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        finished = 1;
      end else begin
        if (tvalid) begin
          if (!first_seen) begin
            first_seen = 1;
            if (mode == 0) chk("first_tvalid_cycle", cyc, 2);
          end
          if (beats >= n) begin
            chk("extra_beat", beats + 1, n);
          end else if (tready) begin
            chk("tdata", longint'($signed(tdata)), longint'(expq[beats]));
            chk("tlast", tlast, (beats == n - 1) ? 1 : 0);
            got.push_back($signed(tdata));
            beats++;
            last_hs = cyc;
            if (beats == abort_at) finished = 1;
          end
        end else if (mode == 0 && first_seen && beats < n) begin
          chk("tvalid_gap", 0, 1);
        end
        stalled = tvalid && !tready;
        held_d = tdata;
        held_l = tlast;
      end
    end
    if (!finished) chk("drain_timeout", beats, n);
  endtask

  typedef struct {
    logic [RW-1:0] x;
    int            sh;
    bit            rl;
    int            expv;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(input longint x, input int sh, input bit rl, input int e);
    vec_t v;
    v.x = RW'(x);
    v.sh = sh;
    v.rl = rl;
    v.expv = e;
    tbl.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    int n, sh;
    bit rl;
    int exp4 [4];

    add(10, 2, 0, 3);
    add(-10, 2, 0, -2);
    add(300, 2, 0, 75);
    add(-300, 2, 0, -75);
    add(longint'(1) << 40, 0, 0, 32767);
    add(-(longint'(1) << 40), 0, 0, -32768);
    add(-5, 0, 1, 0);
    add(100, 0, 1, 100);
    add(7, 1, 0, 4);
    add(-7, 1, 0, -3);
    add(-1, 1, 0, 0);
    add(32768, 0, 0, 32767);
    add(-32769, 0, 0, -32768);
    add(1000, 48, 0, 0);
    add(-(longint'(1) << 47), 47, 0, -1);
    add(-1000, 3, 1, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_tdata", tdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Requantize table, one single-pixel drain per entry.
    for (int i = 0; i < tbl.size(); i++) begin
      mem[0] = tbl[i].x;
      drain(1, tbl[i].sh, tbl[i].rl, i % 3, 0, -1);
      chk("tbl_count", got.size(), 1);
      if (got.size() == 1) chk($sformatf("tbl%0d", i), longint'(got[0]), tbl[i].expv);
    end

    // Four-pixel drain with known results.
    mem[0] = RW'(10); mem[1] = RW'(-10); mem[2] = RW'(300); mem[3] = RW'(-300);
    exp4 = '{3, -2, 75, -75};
    drain(4, 2, 0, 0, 0, -1);
    chk("d4_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("d4_beat%0d", i), longint'(got[i]), exp4[i]);

    // Random memory contents with varied magnitudes.
    for (int i = 0; i < DEPTH; i++) begin
      v = longint'({$urandom, $urandom});
      v = v >>> $urandom_range(0, 47);
      mem[i] = RW'(v);
    end

    // Stalls 1,0,0,1 over eight pixels.
    drain(8, 5, 0, 1, 0, -1);
    chk("stall8_count", got.size(), 8);
    chk("stall8_addr_max", addrb, 7);

    // Zero-length drain, then start ignored while busy.
    drain(0, 0, 0, 0, 0, -1);
    chk("zero_count", got.size(), 0);
    drain(8, 3, 1, 2, 1, -1);
    chk("poke_count", got.size(), 8);

    // Reset at beat 3 of 8 aborts without done.
    drain(8, 2, 0, 1, 0, 3);
    @(posedge clk); #1;
    rst = 1'b0;
    tready = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_enb", enb, 0);
    chk("abort_tvalid", tvalid, 0);
    chk("abort_tlast", tlast, 0);
    chk("abort_addrb", addrb, 0);
    chk("abort_tdata", tdata, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_no_done", done, 0);
    drain(8, 2, 0, 0, 0, -1);
    chk("restart_count", got.size(), 8);

    // Random drains against the reference model.
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 40);
      sh = $urandom_range(0, 48);
      rl = 1'($urandom_range(0, 1));
      drain(n, sh, rl, 2, 0, -1);
      chk("rand_count", got.size(), n);
    end

    // Full depth at full rate.
    drain(DEPTH, 20, 0, 0, 0, -1);
    chk("full_count", got.size(), DEPTH);
    chk("full_addr_end", addrb, DEPTH - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
